// File: rtl/exu_csr_queue.sv
// CSR execute/retire stage with an in-order result FIFO, RAW interlock and flush.
// Optional same-cycle retire path when the FIFO is empty: define CSR_BYPASS_EN.
module exu_csr_queue #(
  parameter int DATA_W     = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int REG_ADDR_W = 5,
  parameter int ID_W       = 3,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                op_i,
  input  logic [DATA_W-1:0]         src_i,
  input  logic [CSR_ADDR_W-1:0]     csr_addr_i,
  input  logic [DATA_W-1:0]         csr_rdata_i,
  input  logic                      csr_we_i,
  input  logic                      reg_we_i,
  input  logic [REG_ADDR_W-1:0]     reg_waddr_i,
  input  logic [ID_W-1:0]           commit_id_i,
  input  logic                      flush_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_W-1:0]     csr_waddr_o,
  output logic [DATA_W-1:0]         csr_wdata_o,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [REG_ADDR_W-1:0]     wb_waddr_o,
  output logic [DATA_W-1:0]         wb_wdata_o,
  output logic [ID_W-1:0]           commit_id_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]         headPtr_q, headPtr_d, tailPtr_q, tailPtr_d;
  logic [AW:0]           count_q, count_d;
  logic                  entCsrWe_q   [DEPTH];
  logic                  entRegWe_q   [DEPTH];
  logic [CSR_ADDR_W-1:0] entCsrAddr_q [DEPTH];
  logic [REG_ADDR_W-1:0] entRegAddr_q [DEPTH];
  logic [ID_W-1:0]       entId_q      [DEPTH];
  logic [DATA_W-1:0]     entOld_q     [DEPTH];
  logic [DATA_W-1:0]     entNew_q     [DEPTH];

  logic [DATA_W-1:0] newVal;
  logic [AW-1:0]     offset;
  logic              hazard, headValid, headRegWe, outEnable;
  logic              retire, push, bypass, enq;

  always_comb begin
    unique case (op_i)
      2'b01:   newVal = src_i;
      2'b10:   newVal = csr_rdata_i | src_i;
      2'b11:   newVal = csr_rdata_i & ~src_i;
      default: newVal = csr_rdata_i;
    endcase
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - headPtr_q;
      if (({1'b0, offset} < count_q) && entCsrWe_q[i] && (entCsrAddr_q[i] == csr_addr_i))
        hazard = 1'b1;
    end
  end

  assign headValid  = (count_q != '0);
  assign headRegWe  = entRegWe_q[headPtr_q];
  assign outEnable  = ~flush_i & ~rst;
  assign retire     = headValid & (wb_ready_i | ~headRegWe) & outEnable;
  assign in_ready_o = (count_q < FULL_CNT) & ~hazard & ~flush_i;
  assign push       = in_valid_i & in_ready_o & ~rst;
`ifdef CSR_BYPASS_EN
  assign bypass     = push & ~headValid & (wb_ready_i | ~reg_we_i);
`else
  assign bypass     = 1'b0;
`endif
  assign enq        = push & ~bypass;
  assign count_o    = count_q;

  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    wb_valid_o  = 1'b0;
    wb_waddr_o  = '0;
    wb_wdata_o  = '0;
    commit_id_o = '0;
    if (bypass) begin
      csr_we_o    = csr_we_i;
      csr_waddr_o = csr_addr_i;
      csr_wdata_o = newVal;
      wb_valid_o  = reg_we_i;
      wb_waddr_o  = reg_waddr_i;
      wb_wdata_o  = csr_rdata_i;
      commit_id_o = commit_id_i;
    end else if (headValid && outEnable) begin
      csr_we_o    = retire & entCsrWe_q[headPtr_q];
      csr_waddr_o = entCsrAddr_q[headPtr_q];
      csr_wdata_o = entNew_q[headPtr_q];
      wb_valid_o  = headRegWe;
      wb_waddr_o  = entRegAddr_q[headPtr_q];
      wb_wdata_o  = entOld_q[headPtr_q];
      commit_id_o = entId_q[headPtr_q];
    end
  end

  // Flush wins over any enqueue or retire in the same cycle.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (flush_i) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      if (retire) headPtr_d = headPtr_q + PTR_ONE;
      if (enq)    tailPtr_d = tailPtr_q + PTR_ONE;
      if (enq && !retire)      count_d = count_q + CNT_ONE;
      else if (!enq && retire) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entCsrWe_q[tailPtr_q]   <= csr_we_i;
      entRegWe_q[tailPtr_q]   <= reg_we_i;
      entCsrAddr_q[tailPtr_q] <= csr_addr_i;
      entRegAddr_q[tailPtr_q] <= reg_waddr_i;
      entId_q[tailPtr_q]      <= commit_id_i;
      entOld_q[tailPtr_q]     <= csr_rdata_i;
      entNew_q[tailPtr_q]     <= newVal;
    end
  end

endmodule

// File: tb/tb_exu_csr_queue.sv
// Randomised and directed bench for exu_csr_queue against a queue-based reference model.
// Reference model follows CSR_BYPASS_EN when that macro is defined for the build.
module tb_exu_csr_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] src_i, csr_rdata_i;
  logic [11:0] csr_addr_i;
  logic        csr_we_i, reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [2:0]  commit_id_i;
  logic        flush_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic [2:0]  commit_id_o;
  logic [2:0]  count_o;

  typedef struct {
    logic        csrWe;
    logic        regWe;
    logic [11:0] addr;
    logic [4:0]  rAddr;
    logic [2:0]  id;
    logic [31:0] oldV;
    logic [31:0] newV;
  } entry_t;

  entry_t model[$];
  int testsRun = 0;
  int testsFailed = 0;

  logic        sInReady, sCsrWe, sWbValid;
  logic [31:0] sCsrWdata, sWbWdata;
  logic [11:0] sCsrWaddr;
  logic [4:0]  sWbWaddr;
  logic [2:0]  sCommitId, sCount;

  always #5 clk = ~clk;

  exu_csr_queue #(.DATA_W(32), .CSR_ADDR_W(12), .REG_ADDR_W(5), .ID_W(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
    .src_i(src_i), .csr_addr_i(csr_addr_i), .csr_rdata_i(csr_rdata_i), .csr_we_i(csr_we_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .commit_id_i(commit_id_i), .flush_i(flush_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o), .commit_id_o(commit_id_o), .count_o(count_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] src,
                               input logic [11:0] addr, input logic [31:0] rdata,
                               input logic cwe, input logic rwe, input logic [4:0] rd,
                               input logic [2:0] id, input logic wbr, input logic fl,
                               input logic r);
    in_valid_i  = v;
    op_i        = op;
    src_i       = src;
    csr_addr_i  = addr;
    csr_rdata_i = rdata;
    csr_we_i    = cwe;
    reg_we_i    = rwe;
    reg_waddr_i = rd;
    commit_id_i = id;
    wb_ready_i  = wbr;
    flush_i     = fl;
    rst         = r;
  endtask

  function automatic logic [31:0] csrResult(input logic [1:0] op, input logic [31:0] old,
                                            input logic [31:0] src);
    case (op)
      2'b01:   return src;
      2'b10:   return old | src;
      2'b11:   return old & ~src;
      default: return old;
    endcase
  endfunction

  // Checks one cycle against the model, then advances model state past the clock edge.
  task automatic runCycle();
    entry_t h;
    entry_t e;
    bit hz, expReady, ret, accept, byp;
    ret = 0; accept = 0; byp = 0;
    #3;
    sInReady = in_ready_o; sCsrWe = csr_we_o; sWbValid = wb_valid_o;
    sCsrWdata = csr_wdata_o; sWbWdata = wb_wdata_o; sCsrWaddr = csr_waddr_o;
    sWbWaddr = wb_waddr_o; sCommitId = commit_id_o; sCount = count_o;
    if (rst) begin
      checkOutput("rst_csr_we", csr_we_o, 0);
      checkOutput("rst_wb_valid", wb_valid_o, 0);
    end else begin
      hz = 0;
      foreach (model[k]) if (model[k].csrWe && model[k].addr == csr_addr_i) hz = 1;
      expReady = (model.size() < DEPTH) && !hz && !flush_i;
      checkOutput("in_ready", in_ready_o, expReady);
      checkOutput("count", count_o, model.size());
      accept = in_valid_i && expReady;
`ifdef CSR_BYPASS_EN
      byp = accept && model.size() == 0 && (wb_ready_i || !reg_we_i);
`endif
      if (byp) begin
        checkOutput("byp_csr_we", csr_we_o, csr_we_i);
        checkOutput("byp_wb_valid", wb_valid_o, reg_we_i);
        checkOutput("byp_csr_wdata", csr_wdata_o, csrResult(op_i, csr_rdata_i, src_i));
        checkOutput("byp_wb_wdata", wb_wdata_o, csr_rdata_i);
        checkOutput("byp_id", commit_id_o, commit_id_i);
      end else if (model.size() > 0 && !flush_i) begin
        h = model[0];
        ret = h.regWe ? wb_ready_i : 1'b1;
        checkOutput("csr_we", csr_we_o, ret && h.csrWe);
        checkOutput("wb_valid", wb_valid_o, h.regWe);
        if (ret && h.csrWe) begin
          checkOutput("csr_waddr", csr_waddr_o, h.addr);
          checkOutput("csr_wdata", csr_wdata_o, h.newV);
        end
        if (h.regWe) begin
          checkOutput("wb_waddr", wb_waddr_o, h.rAddr);
          checkOutput("wb_wdata", wb_wdata_o, h.oldV);
        end
        if (ret) checkOutput("commit_id", commit_id_o, h.id);
      end else begin
        checkOutput("idle_csr_we", csr_we_o, 0);
        checkOutput("idle_wb_valid", wb_valid_o, 0);
      end
    end
    e.csrWe = csr_we_i; e.regWe = reg_we_i; e.addr = csr_addr_i; e.rAddr = reg_waddr_i;
    e.id = commit_id_i; e.oldV = csr_rdata_i; e.newV = csrResult(op_i, csr_rdata_i, src_i);
    @(posedge clk);
    #1;
    if (rst || flush_i) model.delete();
    else begin
      if (ret) void'(model.pop_front());
      if (accept && !byp) model.push_back(e);
    end
  endtask

  task automatic idle(input logic wbr);
    applyStimulus(0, 2'b00, 0, 12'h000, 0, 0, 0, 0, 0, wbr, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 2'b00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    runCycle();
    idle(0);
  endtask

  initial begin
    logic [2:0] nextId;
    logic [11:0] addrSet [4];
    addrSet[0] = 12'h300; addrSet[1] = 12'h301; addrSet[2] = 12'h305; addrSet[3] = 12'h340;
    applyStimulus(0, 2'b00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    doReset();

    // Reset state
    runCycle();
    checkOutput("reset_count", sCount, 0);
    checkOutput("reset_in_ready", sInReady, 1);
    checkOutput("reset_csr_waddr", sCsrWaddr, 0);
    checkOutput("reset_csr_wdata", sCsrWdata, 0);
    checkOutput("reset_wb_wdata", sWbWdata, 0);
    checkOutput("reset_wb_waddr", sWbWaddr, 0);
    checkOutput("reset_commit_id", sCommitId, 0);

    // RS: 0x0F | 0xF0
    applyStimulus(1, 2'b10, 32'hF0, 12'h340, 32'h0F, 1, 1, 5'd3, 3'd0, 1, 0, 0);
    runCycle();
`ifndef CSR_BYPASS_EN
    idle(1);
    runCycle();
`endif
    checkOutput("rs_csr_we", sCsrWe, 1);
    checkOutput("rs_wdata", sCsrWdata, 32'hFF);
    checkOutput("rs_wb_wdata", sWbWdata, 32'h0F);
    idle(1); runCycle();

    // Fill with WB stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'b01, 32'h100 + i, addrSet[i], 32'h10 * i, 1, 1, 5'(i + 1), 3'(i), 0, 0, 0);
      runCycle();
    end
    applyStimulus(1, 2'b01, 32'h9, 12'h7C0, 32'h1, 1, 1, 5'd9, 3'd4, 0, 0, 0);
    runCycle();
    checkOutput("full_count", sCount, 4);
    checkOutput("full_in_ready", sInReady, 0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkOutput("drain_id", sCommitId, 3'(i));
      checkOutput("drain_csr_we", sCsrWe, 1);
    end

    // Full FIFO, retire and offer in the same cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'b01, 32'h200 + i, addrSet[i], 32'h5, 1, 1, 5'd7, 3'(i), 0, 0, 0);
      runCycle();
    end
    applyStimulus(1, 2'b01, 32'hABC, 12'h7C1, 32'h5, 1, 1, 5'd8, 3'd4, 1, 0, 0);
    runCycle();
    checkOutput("fullpop_in_ready", sInReady, 0);
    checkOutput("fullpop_count4", sCount, 4);
    applyStimulus(1, 2'b01, 32'hABC, 12'h7C1, 32'h5, 1, 1, 5'd8, 3'd4, 0, 0, 0);
    runCycle();
    checkOutput("fullpop_accept", sInReady, 1);
    checkOutput("fullpop_count3", sCount, 3);
    idle(0); runCycle();
    checkOutput("fullpop_count4b", sCount, 4);
    idle(1); for (int i = 0; i < 5; i++) runCycle();

    // RAW hazard on 0x300
    applyStimulus(1, 2'b01, 32'h1234, 12'h300, 32'h0, 1, 1, 5'd1, 3'd5, 0, 0, 0);
    runCycle();
    applyStimulus(1, 2'b00, 32'h0, 12'h300, 32'h1234, 0, 1, 5'd2, 3'd6, 0, 0, 0);
    runCycle();
    checkOutput("hazard_stall", sInReady, 0);
    wb_ready_i = 1;
    runCycle();
    checkOutput("hazard_retire_stall", sInReady, 0);
    runCycle();
    checkOutput("hazard_accept", sInReady, 1);
    idle(1); for (int i = 0; i < 3; i++) runCycle();

    // Flush with three queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b01, 32'h7, addrSet[i], 32'h3, 1, 1, 5'd4, 3'(i), 0, 0, 0);
      runCycle();
    end
    applyStimulus(1, 2'b01, 32'h7, 12'h7C2, 32'h3, 1, 1, 5'd4, 3'd3, 1, 1, 0);
    runCycle();
    checkOutput("flush_csr_we", sCsrWe, 0);
    checkOutput("flush_wb_valid", sWbValid, 0);
    idle(1); runCycle();
    checkOutput("post_flush_count", sCount, 0);
    checkOutput("post_flush_ready", sInReady, 1);

    // RC without CSR write
    applyStimulus(1, 2'b11, 32'h00F0, 12'h305, 32'hFFFF, 0, 1, 5'd6, 3'd2, 1, 0, 0);
    runCycle();
`ifndef CSR_BYPASS_EN
    idle(1);
    runCycle();
`endif
    checkOutput("rc_csr_we", sCsrWe, 0);
    checkOutput("rc_wb_valid", sWbValid, 1);
    checkOutput("rc_wb_wdata", sWbWdata, 32'hFFFF);
    idle(1); runCycle();

    // Reset mid-operation
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 2'b01, 32'h55, addrSet[i], 32'h1, 1, 1, 5'd5, 3'(i), 0, 0, 0);
      runCycle();
    end
    applyStimulus(0, 2'b00, 0, 12'h000, 0, 0, 0, 0, 0, 1, 0, 1);
    runCycle();
    checkOutput("midrst_csr_we", sCsrWe, 0);
    idle(1); runCycle();
    checkOutput("midrst_count", sCount, 0);

    // Randomised traffic
    nextId = 0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom,
                    addrSet[$urandom_range(0, 3)], $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), nextId,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 199) == 0);
      if (in_valid_i && in_ready_o) nextId = nextId + 3'd1;
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
